// File: rtl/score_display_scan_pkg.sv
// Shared constants for the score display path: segment codes (active low, gfedcba)
// and the binary-to-BCD conversion state encoding.
package score_display_scan_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

endpackage

// File: rtl/score_display_scan_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes and blank_i give all-off.
module seg7_decode
  import score_display_scan_pkg::*;
(
  input  logic [NIBBLE_W-1:0] bcd_i,
  input  logic                blank_i,
  output logic [6:0]          seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_scan.sv
// Score display: sequential double-dabble conversion of the score word feeding a
// time-multiplexed common-anode seven-segment display.
module score_display_scan
  import score_display_scan_pkg::*;
#(
  parameter int unsigned SCORE_W     = 6,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         seg_n,
  output logic [DIGITS-1:0]  an_n,
  output logic               busy
);

  localparam int unsigned BCD_W  = NIBBLE_W * DIGITS;
  localparam int unsigned WORK_W = BCD_W + SCORE_W;
  localparam int unsigned BIT_W  = $clog2(SCORE_W + 1);
  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCORE_W - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  conv_state_e         state_q;
  logic [SCORE_W-1:0]  snap_q;
  logic                snap_vld_q;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [BIT_W-1:0]    bit_q;
  logic [BCD_W-1:0]    dig_q;
  logic                busy_q;

  logic [REF_W-1:0]    ref_q;
  logic [IDX_W-1:0]    idx_q;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [DIGITS-1:0]   lz_blank;
  logic                lz_run;
  logic [NIBBLE_W-1:0] sel_nib;
  logic                sel_blank;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    work_d = work_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (work_d[SCORE_W + NIBBLE_W*d +: NIBBLE_W] >= 4'd5)
        work_d[SCORE_W + NIBBLE_W*d +: NIBBLE_W] = work_d[SCORE_W + NIBBLE_W*d +: NIBBLE_W] + 4'd3;
    end
    work_d = work_d << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      work_q     <= '0;
      bit_q      <= '0;
      dig_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!snap_vld_q || (score != snap_q)) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          snap_q     <= score;
          snap_vld_q <= 1'b1;
          work_q     <= WORK_W'(score);
          bit_q      <= '0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          work_q <= work_d;
          bit_q  <= bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_q <= DONE;
        end
        DONE: begin
          dig_q   <= work_q[WORK_W-1 -: BCD_W];
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Blank digit i>0 when it and every higher digit are zero; walk from the top down.
  always_comb begin
    lz_run    = 1'b1;
    lz_blank  = '0;
    an_d      = '1;
    sel_nib   = '0;
    sel_blank = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      lz_run = lz_run && (dig_q[(DIGITS-1-k)*NIBBLE_W +: NIBBLE_W] == '0);
      if (BLANK_LZ && (k != DIGITS - 1) && lz_run) lz_blank[DIGITS-1-k] = 1'b1;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_d[i]   = 1'b0;
        sel_nib   = dig_q[i*NIBBLE_W +: NIBBLE_W];
        sel_blank = lz_blank[i];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i   (sel_nib),
    .blank_i (sel_blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign busy  = busy_q;

endmodule
